// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the data-memory responder.
// Size codes, FSM states and default geometry live here.
package dmem_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int DEF_DEPTH_WORDS = 256;
  localparam int DEF_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between a CPU load/store unit
// and the data-memory responder.
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_responder_lane_ctrl.sv
// Byte-lane logic: enables, store replication,
// load lane select/extension and alignment check.
module dmem_lane_ctrl
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [31:0] shifted;

  assign shifted = rword_i >> {off_i, 3'b000};

  always_comb begin
    be_o       = '0;
    wdata_o    = '0;
    rdata_o    = '0;
    misalign_o = 1'b0;
    unique case (1'b1)
      size_i == SZ_BYTE: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~uns_i & shifted[7]}},
                   shifted[7:0]};
      end
      size_i == SZ_HALF: begin
        misalign_o = off_i[0];
        be_o    = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{~uns_i & shifted[15]}},
                   shifted[15:0]};
      end
      size_i == SZ_WORD: begin
        misalign_o = |off_i;
        be_o    = 4'hF;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data memory: accepts one load/store,
// waits WAIT_CYCLES, then holds the response until taken.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          idle;
  logic          op_we, op_uns;
  logic [31:0]   op_addr, op_wdata;
  logic [1:0]    op_size;
  logic [AW-1:0] op_idx;
  logic          oor, misalign, op_err;
  logic [31:0]   rword, lane_wdata, lane_rdata;
  logic [3:0]    be;
  logic          go_resp, mem_we;

  assign idle = (state_q == ST_IDLE);

  // With zero wait states RESP is entered straight from
  // IDLE, so the operation is taken from the live bus.
  assign op_we    = idle ? bus.req_we       : we_q;
  assign op_addr  = idle ? bus.req_addr     : addr_q;
  assign op_wdata = idle ? bus.req_wdata    : wdata_q;
  assign op_size  = idle ? bus.req_size     : size_q;
  assign op_uns   = idle ? bus.req_unsigned : uns_q;

  assign op_idx = op_addr[AW+1:2];
  assign oor    = {2'b00, op_addr[31:2]}
                  >= 32'(DEPTH_WORDS);
  assign rword  = oor ? '0 : mem[op_idx];
  assign op_err = oor | misalign;

  dmem_lane_ctrl u_lane (
    .off_i      (op_addr[1:0]),
    .size_i     (op_size),
    .uns_i      (op_uns),
    .wdata_i    (op_wdata),
    .rword_i    (rword),
    .be_o       (be),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata),
    .misalign_o (misalign)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    go_resp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
          cnt_d   = '0;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (go_resp) begin
      err_d   = op_err;
      rdata_d = (op_err | op_we) ? '0 : lane_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately outside reset; a reset on the
  // commit edge must still suppress the write.
  assign mem_we = go_resp & op_we & ~op_err & ~rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[op_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready = idle & ~rst;
  assign bus.rsp_valid = (state_q == ST_RESP) & ~rst;
  assign bus.rsp_rdata = rst ? '0 : rdata_q;
  assign bus.rsp_err   = err_q & ~rst;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, stall,
// reset-abort and zero-wait cases, then random vs. model.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic clk;
  logic rst;
  int   errs;
  int   checks;

  dmem_responder_if bus ();
  dmem_responder_if bus0 ();

  dmem_responder #(
    .DEPTH_WORDS (256),
    .WAIT_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dmem_responder #(
    .DEPTH_WORDS (256),
    .WAIT_CYCLES (0)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic [7:0] mb [0:1023];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic send_req(input logic we,
                          input logic [31:0] addr,
                          input logic [31:0] wd,
                          input logic [1:0] sz,
                          input logic un);
    int n;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_size     = sz;
    bus.req_unsigned = un;
    n = 0;
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) break;
    end
    if (!bus.rsp_valid) chk("rsp_valid_timeout", 0, 1);
  endtask

  task automatic do_txn(input logic we,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input logic [1:0] sz,
                        input logic un,
                        output logic [31:0] rd,
                        output logic er,
                        output int lat);
    bus.rsp_ready = 1'b1;
    send_req(we, addr, wd, sz, un);
    wait_rsp(lat);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn0(input logic we,
                         input logic [31:0] addr,
                         input logic [31:0] wd,
                         output logic [31:0] rd,
                         output int lat);
    @(negedge clk);
    bus0.rsp_ready    = 1'b1;
    bus0.req_valid    = 1'b1;
    bus0.req_we       = we;
    bus0.req_addr     = addr;
    bus0.req_wdata    = wd;
    bus0.req_size     = SZ_WORD;
    bus0.req_unsigned = 1'b0;
    chk("w0_req_ready", 32'(bus0.req_ready), 1);
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus0.rsp_valid) break;
    end
    rd = bus0.rsp_rdata;
    @(posedge clk);
    #1;
  endtask

  // Reference: byte-addressed little-endian memory.
  task automatic model(input logic we,
                       input logic [31:0] addr,
                       input logic [31:0] wd,
                       input logic [1:0] sz,
                       input logic un,
                       output logic [31:0] rd,
                       output logic er);
    int nb;
    logic [31:0] v;
    nb = 1 << sz;
    er = (sz == 2'd3) || (addr % nb != 0) ||
         ((addr / 4) >= 256);
    rd = 0;
    if (er) return;
    if (we) begin
      for (int i = 0; i < nb; i++)
        mb[addr + i] = wd[8*i +: 8];
      return;
    end
    v = 0;
    for (int i = 0; i < nb; i++)
      v[8*i +: 8] = mb[addr + i];
    if (!un && v[8*nb-1])
      for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
    rd = v;
  endtask

  initial begin
    vec_t        tbl [15];
    logic [31:0] rd, exp_rd, held_rd;
    logic        er, exp_er, held_er, seen;
    int          lat;
    logic        we, un;
    logic [31:0] addr, wd;
    logic [1:0]  sz;

    errs   = 0;
    checks = 0;
    bus.req_valid     = 1'b0;
    bus.req_we        = 1'b0;
    bus.req_addr      = '0;
    bus.req_wdata     = '0;
    bus.req_size      = SZ_BYTE;
    bus.req_unsigned  = 1'b0;
    bus.rsp_ready     = 1'b1;
    bus0.req_valid    = 1'b0;
    bus0.req_we       = 1'b0;
    bus0.req_addr     = '0;
    bus0.req_wdata    = '0;
    bus0.req_size     = SZ_WORD;
    bus0.req_unsigned = 1'b0;
    bus0.rsp_ready    = 1'b1;

    tbl[0]  = '{1, 28, 32'd10, SZ_WORD, 0, 0, 0};
    tbl[1]  = '{0, 28, 0, SZ_WORD, 0, 32'h0000000A, 0};
    tbl[2]  = '{1, 4, 32'h11223344, SZ_WORD, 0, 0, 0};
    tbl[3]  = '{1, 5, 32'h00000080, SZ_BYTE, 0, 0, 0};
    tbl[4]  = '{0, 5, 0, SZ_BYTE, 0, 32'hFFFFFF80, 0};
    tbl[5]  = '{0, 5, 0, SZ_BYTE, 1, 32'h00000080, 0};
    tbl[6]  = '{0, 4, 0, SZ_WORD, 0, 32'h11228044, 0};
    tbl[7]  = '{0, 3, 0, SZ_HALF, 0, 0, 1};
    tbl[8]  = '{1, 0, 32'hCAFEF00D, SZ_WORD, 0, 0, 0};
    tbl[9]  = '{1, 32'h400, 32'hDEADBEEF, SZ_WORD, 0, 0, 1};
    tbl[10] = '{0, 0, 0, SZ_WORD, 0, 32'hCAFEF00D, 0};
    tbl[11] = '{0, 4, 0, SZ_HALF, 0, 32'hFFFF8044, 0};
    tbl[12] = '{0, 6, 0, SZ_HALF, 1, 32'h00001122, 0};
    tbl[13] = '{1, 5, 32'h0000FFFF, SZ_HALF, 0, 0, 1};
    tbl[14] = '{0, 8, 0, 2'd3, 0, 0, 1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.req_ready), 1);

    foreach (tbl[i]) begin
      do_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata,
             tbl[i].size, tbl[i].uns, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd,
          tbl[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er),
          32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 3);
    end
    do_txn(0, 4, 0, SZ_WORD, 0, rd, er, lat);
    chk("word4_after_bad_half", rd, 32'h11228044);

    // Response held off for five cycles.
    bus.rsp_ready = 1'b0;
    send_req(0, 28, 0, SZ_WORD, 0);
    wait_rsp(lat);
    held_rd = bus.rsp_rdata;
    held_er = bus.rsp_err;
    chk("stall_rdata", held_rd, 32'h0000000A);
    chk("stall_lat", 32'(lat), 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.rsp_valid), 1);
      chk("stall_hold_rdata", bus.rsp_rdata, held_rd);
      chk("stall_hold_err", 32'(bus.rsp_err),
          32'(held_er));
      chk("stall_req_ready", 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", 32'(bus.rsp_valid), 0);
    chk("stall_release_ready", 32'(bus.req_ready), 1);

    // Reset lands on the edge that would commit the store.
    do_txn(1, 8, 32'h5555AAAA, SZ_WORD, 0, rd, er, lat);
    send_req(1, 8, 32'h00001234, SZ_WORD, 0);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen |= bus.rsp_valid;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= bus.rsp_valid;
    end
    chk("abort_no_rsp", 32'(seen), 0);
    do_txn(0, 8, 0, SZ_WORD, 0, rd, er, lat);
    chk("abort_old_value", rd, 32'h5555AAAA);

    do_txn0(1, 12, 32'h00000077, rd, lat);
    chk("w0_store_lat", 32'(lat), 1);
    do_txn0(0, 12, 0, rd, lat);
    chk("w0_load_lat", 32'(lat), 1);
    chk("w0_load_rdata", rd, 32'h00000077);

    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      model(1, 32'(4*w), wd, SZ_WORD, 0, exp_rd, exp_er);
      do_txn(1, 32'(4*w), wd, SZ_WORD, 0, rd, er, lat);
      chk("init_err", 32'(er), 32'(exp_er));
    end
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom);
      un = 1'($urandom);
      wd = $urandom;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 :
           2'($urandom_range(0, 2));
      addr = ($urandom_range(0, 9) == 0) ?
             32'h400 + $urandom_range(0, 255) :
             $urandom_range(0, 63);
      model(we, addr, wd, sz, un, exp_rd, exp_er);
      do_txn(we, addr, wd, sz, un, rd, er, lat);
      chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
      chk($sformatf("rnd%0d_err", i), 32'(er),
          32'(exp_er));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 3);
    end

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
